// File: rtl/gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gearbox_pkg
// Description : Shared state encoding for the 2:1 / 1:2 gearbox stages.
// Revision    : 1.0 - initial release
// ============================================================================
package gearbox_pkg;

    typedef enum logic [1:0] {
        GB_EMPTY  = 2'd0,
        GB_FIRST  = 2'd1,
        GB_SECOND = 2'd2
    } gearbox_state_t;

    // Plain-vector views of the states for legacy-style FSM code.
    localparam logic [1:0] C_ST_EMPTY  = 2'(GB_EMPTY);
    localparam logic [1:0] C_ST_FIRST  = 2'(GB_FIRST);
    localparam logic [1:0] C_ST_SECOND = 2'(GB_SECOND);

endpackage : gearbox_pkg
`default_nettype wire

// File: rtl/gearbox_2_to_1.sv
`default_nettype none
// ============================================================================
// Module      : gearbox_2_to_1
// Description : Splits each 2*WIDTH upstream word into two WIDTH-bit words.
// Revision    : 1.0 - initial release
// ============================================================================
module gearbox_2_to_1
    import gearbox_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_vld,
    output logic               up_rdy,
    input  logic [2*WIDTH-1:0] up_data,
    output logic               down_vld,
    input  logic               down_rdy,
    output logic [WIDTH-1:0]   down_data
);

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_buf;
    logic [1:0]         w_state_nxt;
    logic               w_up_xfer;
    logic               w_down_xfer;
    logic [WIDTH-1:0]   w_first_half;
    logic [WIDTH-1:0]   w_second_half;

    generate
        if (HI_FIRST) begin : g_hi_first
            assign w_first_half  = r_buf[2*WIDTH-1:WIDTH];
            assign w_second_half = r_buf[WIDTH-1:0];
        end else begin : g_lo_first
            assign w_first_half  = r_buf[WIDTH-1:0];
            assign w_second_half = r_buf[2*WIDTH-1:WIDTH];
        end
    endgenerate

    // down_rdy feeds up_rdy combinationally so SECOND can refill without a bubble.
    assign up_rdy      = ~rst & ((r_state == C_ST_EMPTY) |
                                 ((r_state == C_ST_SECOND) & down_rdy));
    assign down_vld    = ~rst & (r_state != C_ST_EMPTY);
    assign w_up_xfer   = up_vld & up_rdy;
    assign w_down_xfer = down_vld & down_rdy;

    always_comb begin
        w_state_nxt = r_state;
        down_data   = '0;
        case (r_state)
            C_ST_EMPTY: begin
                if (w_up_xfer) w_state_nxt = C_ST_FIRST;
            end
            C_ST_FIRST: begin
                down_data = rst ? '0 : w_first_half;
                if (w_down_xfer) w_state_nxt = C_ST_SECOND;
            end
            C_ST_SECOND: begin
                down_data = rst ? '0 : w_second_half;
                if (w_down_xfer) w_state_nxt = w_up_xfer ? C_ST_FIRST : C_ST_EMPTY;
            end
            default: w_state_nxt = C_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_EMPTY;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_up_xfer) r_buf <= up_data;
        end
    end

endmodule : gearbox_2_to_1
`default_nettype wire
